instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder. It holds the fetch PC and issues requests to instruction memory over a req/ack interface that tolerates variable latency. Returned words are buffered in a small FIFO and presented to the decoder with a valid/ready handshake. The branch unit can redirect the fetch PC, which flushes the FIFO and any request in flight.

---
 rtl/instr_fetch_unit.sv | 106 ++++++++++
 tb/tb_instr_fetch_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC, single-outstanding imem requester and instruction FIFO feeding decode.
// Define IFETCH_MISALIGN_CHK_EN to trap misaligned redirect targets instead of forcing alignment.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_next,
    output logic        fetch_misaligned
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DISCARD = 2'd2;
`ifdef IFETCH_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic [1:0]    state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, req_addr_q, req_addr_d;
    logic [CW-1:0] count_q, count_d, cnt_after;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic          mis_q, mis_d;
    logic [31:0]   fifo_instr_q [FIFO_DEPTH];
    logic [31:0]   fifo_pc_q [FIFO_DEPTH];
    logic [31:0]   tgt;
    logic          push, pop;
    assign tgt = CHK ? redirect_pc : {redirect_pc[31:2], 2'b00};
    assign push = (state_q == S_BUSY) && imem_ack && !redirect;
    assign pop = instr_valid && instr_ready;
    assign cnt_after = count_q + CW'(push) - CW'(pop);
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = redirect ? tgt : fetch_pc_q;
        req_addr_d = req_addr_q;
        mis_d      = redirect ? (CHK && (redirect_pc[1:0] != 2'b00)) : mis_q;
        count_d    = redirect ? '0 : cnt_after;
        rd_d       = redirect ? '0 : (pop ? rd_q + 1'b1 : rd_q);
        wr_d       = redirect ? '0 : (push ? wr_q + 1'b1 : wr_q);
        case (state_q)
            S_IDLE: begin
                if (!redirect && !mis_q && count_q < DEPTH) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (redirect) begin
                    state_d = imem_ack ? S_IDLE : S_DISCARD;
                end else if (imem_ack) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    // keep streaming while the post-push/pop FIFO still has room
                    if (cnt_after < DEPTH) req_addr_d = fetch_pc_q + 32'd4;
                    else state_d = S_IDLE;
                end
            end
            S_DISCARD: state_d = imem_ack ? S_IDLE : S_DISCARD;
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
            count_q    <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            mis_q      <= mis_d;
        end
    end
    // Storage needs no reset: outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wr_q] <= imem_rdata;
            fifo_pc_q[wr_q]    <= req_addr_q;
        end
    end
    assign imem_req         = (state_q == S_BUSY) || (state_q == S_DISCARD);
    assign imem_addr        = req_addr_q;
    assign instr_valid      = count_q != '0;
    assign instruction      = instr_valid ? fifo_instr_q[rd_q] : '0;
    assign instr_pc         = instr_valid ? fifo_pc_q[rd_q] : '0;
    assign instr_pc_next    = instr_pc + 32'd4;
    assign fetch_misaligned = CHK && mis_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table-driven, directed and randomized checks of instr_fetch_unit.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack, redirect, instr_valid, instr_ready, fetch_misaligned;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instruction, instr_pc, instr_pc_next;
    int          mem_lat = 0;
    int          wc = 0;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
    } vec_t;
    vec_t tbl [20];

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .instr_pc(instr_pc), .instr_pc_next(instr_pc_next),
        .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1;
    endfunction

    // Memory: acknowledges once the request has been held for mem_lat cycles.
    assign imem_ack   = imem_req && (wc >= mem_lat);
    assign imem_rdata = word_of(imem_addr);
    always @(posedge clk or posedge rst) begin
        if (rst) wc <= 0;
        else if (!imem_req || imem_ack) wc <= 0;
        else wc <= wc + 1;
    end

    function automatic vec_t mk(input logic rdy, input logic rd, input logic [31:0] rpc,
                                input logic req, input logic [31:0] addr, input logic v,
                                input logic [31:0] pc);
        vec_t r;
        r.rdy = rdy; r.rd = rd; r.rpc = rpc; r.req = req; r.addr = addr; r.v = v; r.pc = pc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, v});
        chk({tag, ".pc"}, instr_pc, v ? pc : 32'h0);
        chk({tag, ".instr"}, instruction, v ? word_of(pc) : 32'h0);
        chk({tag, ".pc_next"}, instr_pc_next, (v ? pc : 32'h0) + 32'd4);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic rd, input logic [31:0] rpc);
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    // Leaves the bench at cycle 0: reset just released, next edge is the first active one.
    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        mem_lat = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req", {31'b0, imem_req}, 32'h0);
        chk("rst.addr", imem_addr, 32'h0);
        chk_head("rst", 1'b0, 32'h0);
        chk("rst.mis", {31'b0, fetch_misaligned}, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc, prev_addr, rpc;
        logic        prev_hold, flush_pend, rdy, rd, got;
        int          xfers;
        // Zero-wait memory: stall from reset, drain, stream, then redirect on an ack cycle.
        tbl[0]  = mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0);
        tbl[1]  = mk(0, 0, 32'h0,   1, 32'h0,  0, 32'h0);
        tbl[2]  = mk(0, 0, 32'h0,   1, 32'h4,  1, 32'h0);
        for (int i = 3; i <= 10; i++) tbl[i] = mk(0, 0, 32'h0, 0, 32'h4, 1, 32'h0);
        tbl[11] = mk(1, 0, 32'h0,   0, 32'h4,  1, 32'h0);
        tbl[12] = mk(1, 0, 32'h0,   0, 32'h4,  1, 32'h4);
        tbl[13] = mk(1, 0, 32'h0,   1, 32'h8,  0, 32'h0);
        tbl[14] = mk(1, 0, 32'h0,   1, 32'hC,  1, 32'h8);
        tbl[15] = mk(0, 1, 32'h200, 1, 32'h10, 1, 32'hC);
        tbl[16] = mk(1, 0, 32'h0,   0, 32'h10, 0, 32'h0);
        tbl[17] = mk(1, 0, 32'h0,   1, 32'h200, 0, 32'h0);
        tbl[18] = mk(1, 0, 32'h0,   1, 32'h204, 1, 32'h200);
        tbl[19] = mk(1, 0, 32'h0,   1, 32'h208, 1, 32'h204);
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (i > 0) cyc();
            chk($sformatf("tbl%0d.req", i), {31'b0, imem_req}, {31'b0, tbl[i].req});
            chk($sformatf("tbl%0d.addr", i), imem_addr, tbl[i].addr);
            chk_head($sformatf("tbl%0d", i), tbl[i].v, tbl[i].pc);
            drive(tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
        end

        // Redirect during a slow request: old word is discarded, address held until ack.
        do_reset();
        drive(1'b1, 1'b0, 32'h0);
        mem_lat = 3;
        cyc();
        chk("disc.c1.req", {31'b0, imem_req}, 32'h1);
        drive(1'b1, 1'b1, 32'h100);
        for (int c = 2; c <= 4; c++) begin
            cyc();
            drive(1'b1, 1'b0, 32'h0);
            chk($sformatf("disc.c%0d.req", c), {31'b0, imem_req}, 32'h1);
            chk($sformatf("disc.c%0d.addr", c), imem_addr, 32'h0);
            chk($sformatf("disc.c%0d.valid", c), {31'b0, instr_valid}, 32'h0);
        end
        cyc();
        mem_lat = 0;
        chk("disc.c5.req", {31'b0, imem_req}, 32'h0);
        chk("disc.c5.valid", {31'b0, instr_valid}, 32'h0);
        cyc();
        chk("disc.c6.req", {31'b0, imem_req}, 32'h1);
        chk("disc.c6.addr", imem_addr, 32'h100);
        chk("disc.c6.valid", {31'b0, instr_valid}, 32'h0);
        cyc();
        chk_head("disc.c7", 1'b1, 32'h100);
        chk("disc.c7.addr", imem_addr, 32'h104);

        // PC wrap at the top of the address space.
        do_reset();
        drive(1'b1, 1'b1, 32'hFFFF_FFFC);
        cyc();
        drive(1'b1, 1'b0, 32'h0);
        chk("wrap.c1.req", {31'b0, imem_req}, 32'h0);
        cyc();
        chk("wrap.c2.addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap.c2.req", {31'b0, imem_req}, 32'h1);
        cyc();
        chk("wrap.c3.addr", imem_addr, 32'h0);
        chk_head("wrap.c3", 1'b1, 32'hFFFF_FFFC);
        cyc();
        chk_head("wrap.c4", 1'b1, 32'h0);

        // Misaligned redirect target.
        do_reset();
        drive(1'b1, 1'b0, 32'h0);
        repeat (3) cyc();
        drive(1'b1, 1'b1, 32'h102);
        cyc();
        drive(1'b1, 1'b0, 32'h0);
        chk("mis.c4.req", {31'b0, imem_req}, 32'h0);
`ifdef IFETCH_MISALIGN_CHK_EN
        chk("mis.c4.flag", {31'b0, fetch_misaligned}, 32'h1);
        for (int c = 5; c <= 8; c++) begin
            cyc();
            chk($sformatf("mis.c%0d.req", c), {31'b0, imem_req}, 32'h0);
            chk($sformatf("mis.c%0d.valid", c), {31'b0, instr_valid}, 32'h0);
            chk($sformatf("mis.c%0d.flag", c), {31'b0, fetch_misaligned}, 32'h1);
        end
        drive(1'b1, 1'b1, 32'h104);
        cyc();
        drive(1'b1, 1'b0, 32'h0);
        chk("mis.c9.flag", {31'b0, fetch_misaligned}, 32'h0);
        cyc();
        chk("mis.c10.req", {31'b0, imem_req}, 32'h1);
        chk("mis.c10.addr", imem_addr, 32'h104);
        cyc();
        chk_head("mis.c11", 1'b1, 32'h104);
`else
        chk("mis.c4.flag", {31'b0, fetch_misaligned}, 32'h0);
        cyc();
        chk("mis.c5.req", {31'b0, imem_req}, 32'h1);
        chk("mis.c5.addr", imem_addr, 32'h100);
        cyc();
        chk_head("mis.c6", 1'b1, 32'h100);
`endif

        // Random traffic against a stream model: deliveries follow target, target+4, ...
        do_reset();
        exp_pc = 32'h0;
        prev_hold = 1'b0;
        prev_addr = 32'h0;
        flush_pend = 1'b0;
        xfers = 0;
        for (int n = 0; n < 4000; n++) begin
            cyc();
            if (flush_pend) chk("rnd.flush", {31'b0, instr_valid}, 32'h0);
            if (prev_hold) chk("rnd.addr_hold", imem_addr, prev_addr);
            chk("rnd.mis", {31'b0, fetch_misaligned}, 32'h0);
            mem_lat = int'($urandom_range(0, 3));
            rdy = ($urandom_range(0, 2) != 0);
            rd = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
            drive(rdy, rd, rpc);
            #1;
            prev_hold = imem_req && !imem_ack;
            prev_addr = imem_addr;
            if (instr_valid && rdy) begin
                chk("rnd.pc", instr_pc, exp_pc);
                chk("rnd.instr", instruction, word_of(exp_pc));
                chk("rnd.pc_next", instr_pc_next, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                xfers++;
            end
            if (rd) exp_pc = rpc;
            flush_pend = rd;
        end
        chk("rnd.xfers_seen", {31'b0, xfers > 100}, 32'h1);

        // Bounded wait for the fetch stream to resume after random traffic.
        drive(1'b1, 1'b0, 32'h0);
        mem_lat = 0;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            cyc();
            if (instr_valid) begin
                got = 1'b1;
                chk("live.pc", instr_pc, exp_pc);
            end
        end
        chk("live.valid_seen", {31'b0, got}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
